// File: rtl/async_fifo_core.sv
// async_fifo_core: single-clock first-word-fall-through FIFO with wrap-bit pointers and async active-low reset
module async_fifo_core #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ptr_one = 1;
  logic [DATA_WIDTH-1:0] mem [depth];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) && (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];
  // memory is cleared on reset so rd_data reads 0 while empty after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + ptr_one;
      end
      if (do_rd) rd_ptr <= rd_ptr + ptr_one;
    end
endmodule

// File: tb/tb_async_fifo_core.sv
// tb_async_fifo_core: directed self-checking bench for async_fifo_core
module tb_async_fifo_core;
  logic clk = 0;
  logic rst_n = 0;
  logic wr_en = 0;
  logic rd_en = 0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data;
  logic full, empty;
  int checks = 0;
  int failures = 0;
  async_fifo_core dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic we, input logic [15:0] wd, input logic re);
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    @(posedge clk);
    #1;
    wr_en = 0;
    rd_en = 0;
  endtask
  int q[$];
  int wi;
  logic re;
  initial begin
    #2;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_data", rd_data, 0);
    #10 rst_n = 1;
    @(posedge clk);
    #1;
    // three writes, three reads
    step(1, 100, 0);
    check("w1_empty", empty, 0);
    check("w1_head", rd_data, 100);
    step(1, 101, 0);
    step(1, 102, 0);
    for (int i = 0; i < 3; i++) begin
      check("r3_head", rd_data, 100 + i);
      step(0, 0, 1);
    end
    check("r3_empty", empty, 1);
    // fill to full
    for (int i = 0; i < 16; i++) begin
      check("fill_notfull", full, 0);
      step(1, 16'(100 + i), 0);
    end
    check("fill_full", full, 1);
    step(1, 999, 0);
    check("ovf_full", full, 1);
    check("ovf_head", rd_data, 100);
    step(1, 500, 1);
    check("fullrw_full", full, 0);
    check("fullrw_head", rd_data, 101);
    for (int i = 1; i < 16; i++) begin
      check("drain_head", rd_data, 100 + i);
      step(0, 0, 1);
    end
    check("drain_empty", empty, 1);
    // simultaneous read/write while empty
    step(1, 7, 1);
    check("emptyrw_empty", empty, 0);
    check("emptyrw_head", rd_data, 7);
    step(0, 0, 1);
    check("emptyrw_pop", empty, 1);
    // interleaved traffic against a queue model
    wi = 0;
    for (int c = 0; c < 100 && (wi < 30 || q.size() > 0); c++) begin
      re = (c % 2 == 1) && q.size() > 0;
      if (re) check("il_head", rd_data, q[0]);
      step(wi < 30, 16'(100 + wi), re);
      if (re) void'(q.pop_front());
      if (wi < 30) begin
        q.push_back(100 + wi);
        wi++;
      end
      check("il_full", full, 0);
      check("il_empty", empty, q.size() == 0);
    end
    check("il_done", q.size(), 0);
    // mid-operation reset pulse
    for (int i = 1; i <= 5; i++) step(1, 16'(i), 0);
    check("pre_rst_head", rd_data, 1);
    #2 rst_n = 0;
    #0.5;
    check("mid_rst_empty", empty, 1);
    check("mid_rst_full", full, 0);
    check("mid_rst_data", rd_data, 0);
    #0.5 rst_n = 1;
    check("post_rst_empty", empty, 1);
    step(1, 42, 0);
    check("post_rst_head", rd_data, 42);
    check("post_rst_nonempty", empty, 0);
    step(0, 0, 1);
    check("post_rst_pop", empty, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/async_fifo_core.md
ASYNC_FIFO_CORE -- requirements
Module: async_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the width of one stored word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, giving depth 2**ADDR_WIDTH = 16 words.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-006 The block SHALL have port wr_en, input, width 1: write request.
REQ-007 The block SHALL have port wr_data, input, width DATA_WIDTH: word to write.
REQ-008 The block SHALL have port rd_en, input, width 1: read (pop) request.
REQ-009 The block SHALL have port rd_data, output, width DATA_WIDTH: head-of-queue word, first-word-fall-through.
REQ-010 The block SHALL have port full, output, width 1: asserted when 16 words are stored.
REQ-011 The block SHALL have port empty, output, width 1: asserted when 0 words are stored.

Function
REQ-012 Storage SHALL be a 2**ADDR_WIDTH x DATA_WIDTH register array addressed by write and read pointers that are each ADDR_WIDTH+1 bits wide.
REQ-013 A write SHALL be accepted on a rising clk edge when wr_en=1 and full=0; mem[wr_ptr[ADDR_WIDTH-1:0]] SHALL get wr_data and wr_ptr SHALL increment by 1.
REQ-014 A read SHALL be accepted on a rising clk edge when rd_en=1 and empty=0; rd_ptr SHALL increment by 1.
REQ-015 wr_en while full=1 SHALL be ignored: no storage change and no pointer change, even if rd_en=1 on the same edge.
REQ-016 rd_en while empty=1 SHALL be ignored: no pointer change, even if wr_en=1 on the same edge.
REQ-017 When wr_en=rd_en=1 with 0 < count < 16, both operations SHALL occur on the same edge and the count SHALL be unchanged.
REQ-018 Pointers SHALL wrap modulo 2**(ADDR_WIDTH+1); the address bits SHALL wrap from 15 to 0.
REQ-019 empty SHALL be combinational from the registered pointers: empty = (wr_ptr == rd_ptr).
REQ-020 full SHALL be combinational from the registered pointers: MSBs differ and the lower ADDR_WIDTH bits are equal.
REQ-021 rd_data SHALL equal mem[rd_ptr[ADDR_WIDTH-1:0]] combinationally, so the head word is valid whenever empty=0, before rd_en is asserted.
REQ-022 Flag latency: after an accepted write at edge N into an empty FIFO, empty SHALL be 0 immediately after edge N.
REQ-023 Flag latency: full SHALL assert immediately after the edge accepting the 16th word, and deassert immediately after the next accepted read.
REQ-024 Data SHALL be returned strictly in write order with no loss or duplication.

Reset
REQ-025 While rst_n=0, wr_ptr and rd_ptr SHALL be 0 and every memory word SHALL be 0, asynchronously.
REQ-026 During reset: empty=1, full=0 and rd_data=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored data immediately.
REQ-028 After reset release, the first clk edge SHALL accept operations normally.

Verification
REQ-029 Scenario: reset, then write 100,101,102 one per cycle, then read 3 -> rd_data shows 100,101,102 in order; empty=1 after the third read.
REQ-030 Scenario: write 16 words (100..115) with no reads -> full=1 after the 16th edge; a 17th write of 999 is ignored; 16 reads return 100..115; empty=1.
REQ-031 Scenario: interleave 30 writes (100..129) and 30 reads, with reads at one edge per two cycles -> all 30 values are read in order, full never asserts, and there is no write while full or read while empty.
REQ-032 Scenario: when full, assert wr_en=rd_en=1 with wr_data=500 -> one word is popped, 500 is not stored, and full=0 afterwards.
REQ-033 Scenario: when empty, assert wr_en=rd_en=1 with wr_data=7 -> 7 is stored, empty=0 and rd_data=7.
REQ-034 Scenario: with 5 words stored, pulse rst_n low for 1 ns between edges -> empty=1, full=0 and rd_data=0 at once; a subsequent write of 42 is read back as 42.
